// File: rtl/des_pkg.sv
// Shared DES permutation constants: IP/FP source-bit tables, mode encodings, block width
// and the output-buffer occupancy states.
package des_pkg;

   localparam int unsigned DES_BLK_W = 64;

   localparam logic DES_MODE_IP = 1'b0;
   localparam logic DES_MODE_FP = 1'b1;

   typedef int unsigned perm_table_t [1:64];

   // Entry i names the input bit (DES numbering, 1 = MSB) that lands on output bit i.
   localparam perm_table_t IP_TABLE = '{
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,
      64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7
   };

   localparam perm_table_t FP_TABLE = '{
      40,  8, 48, 16, 56, 24, 64, 32,
      39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,
      37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,
      35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,
      33,  1, 41,  9, 49, 17, 57, 25
   };

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_FULL
   } buf_state_t;

endpackage

// File: rtl/des_perm_pipe_if.sv
// Valid/ready stream bundle for the DES permutation stage; slave is the stage side,
// master is the source/sink side.
interface des_perm_pipe_if #(
   parameter int unsigned LANES = 1
);
   localparam int unsigned W = des_pkg::DES_BLK_W * LANES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_mode;
   logic         in_swap;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_mode;

   modport master (
      output in_valid, in_data, in_mode, in_swap, out_ready,
      input  in_ready, out_valid, out_data, out_mode
   );

   modport slave (
      input  in_valid, in_data, in_mode, in_swap, out_ready,
      output in_ready, out_valid, out_data, out_mode
   );

endinterface

// File: rtl/des_perm_lane.sv
// Combinational DES IP / FP permutation of one 64-bit block, with optional half swap
// ahead of FP.
module des_perm_lane
   import des_pkg::*;
(
   input  logic [DES_BLK_W-1:0] blk,
   input  logic                 mode,
   input  logic                 swap,
   output logic [DES_BLK_W-1:0] perm
);

   logic [DES_BLK_W-1:0] src;
   logic [DES_BLK_W-1:0] ip_blk;
   logic [DES_BLK_W-1:0] fp_blk;

   assign src = (mode == DES_MODE_FP && swap) ? {blk[31:0], blk[63:32]} : blk;

   // DES bit n sits at vector index DES_BLK_W-n.
   for (genvar i = 1; i <= 64; i++) begin : g_bit
      assign ip_blk[DES_BLK_W-i] = src[DES_BLK_W-IP_TABLE[i]];
      assign fp_blk[DES_BLK_W-i] = src[DES_BLK_W-FP_TABLE[i]];
   end

   assign perm = (mode == DES_MODE_IP) ? ip_blk : fp_blk;

endmodule

// File: rtl/des_perm_pipe.sv
// Registered DES permutation stage: LANES parallel IP/FP permutations behind a
// 2-entry FIFO output buffer with valid/ready on both sides and an accepted-beat counter.
module des_perm_pipe
   import des_pkg::*;
#(
   parameter int unsigned LANES = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   des_perm_pipe_if.slave   bus,
   output logic [CNT_W-1:0] beat_cnt
);

   localparam int unsigned W = DES_BLK_W * LANES;

   logic [W-1:0] perm_data;
   logic [W-1:0] head_data;
   logic [W-1:0] tail_data;
   logic         head_mode;
   logic         tail_mode;
   logic         ready_q;
   logic         take;
   logic         pop;
   logic         head_ld_in;
   logic         head_ld_tail;
   logic         tail_ld;

   buf_state_t state;
   buf_state_t state_nx;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      des_perm_lane u_lane (
         .blk  (bus.in_data[W-1-DES_BLK_W*k -: DES_BLK_W]),
         .mode (bus.in_mode),
         .swap (bus.in_swap),
         .perm (perm_data[W-1-DES_BLK_W*k -: DES_BLK_W])
      );
   end

   assign take          = bus.in_valid && ready_q;
   assign pop           = (state != BUF_EMPTY) && bus.out_ready;
   assign bus.in_ready  = ready_q;
   assign bus.out_valid = (state != BUF_EMPTY);
   assign bus.out_data  = head_data;
   assign bus.out_mode  = head_mode;

   // Head register drives the outputs; tail only fills when the head is still pending.
   always_comb begin
      state_nx     = state;
      head_ld_in   = 1'b0;
      head_ld_tail = 1'b0;
      tail_ld      = 1'b0;
      unique case (state)
         BUF_EMPTY: begin
            if (take) begin
               state_nx   = BUF_ONE;
               head_ld_in = 1'b1;
            end
         end
         BUF_ONE: begin
            if (take && !pop) begin
               state_nx = BUF_FULL;
               tail_ld  = 1'b1;
            end else if (pop && !take) begin
               state_nx = BUF_EMPTY;
            end else if (take && pop) begin
               head_ld_in = 1'b1;
            end
         end
         BUF_FULL: begin
            if (pop) begin
               state_nx     = BUF_ONE;
               head_ld_tail = 1'b1;
            end
         end
         default: state_nx = BUF_EMPTY;
      endcase
   end

   // ready_q is held low through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BUF_EMPTY;
         ready_q   <= 1'b0;
         head_data <= '0;
         head_mode <= 1'b0;
         tail_data <= '0;
         tail_mode <= 1'b0;
         beat_cnt  <= '0;
      end else begin
         state   <= state_nx;
         ready_q <= (state_nx != BUF_FULL);
         if (head_ld_in) begin
            head_data <= perm_data;
            head_mode <= bus.in_mode;
         end else if (head_ld_tail) begin
            head_data <= tail_data;
            head_mode <= tail_mode;
         end
         if (tail_ld) begin
            tail_data <= perm_data;
            tail_mode <= bus.in_mode;
         end
         if (take) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: a 4-lane/16-bit-counter instance plus a 1-lane/4-bit-counter
// instance sharing the handshake, checked against a queue-based reference model.
module tb_des_perm_pipe;
   import des_pkg::*;

   localparam int unsigned LANES = 4;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned W     = DES_BLK_W * LANES;

   typedef struct {
      logic [W-1:0] data;
      logic         mode;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CNT_W-1:0] beat_cnt;
   logic [3:0]       beat_cnt1;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned mcnt    = 0;
   beat_t       sb[$];

   always #5 clk = ~clk;

   des_perm_pipe_if #(.LANES(LANES)) bus ();
   des_perm_pipe_if #(.LANES(1))     bus1 ();

   assign bus1.in_valid  = bus.in_valid;
   assign bus1.in_data   = bus.in_data[W-1 -: 64];
   assign bus1.in_mode   = bus.in_mode;
   assign bus1.in_swap   = bus.in_swap;
   assign bus1.out_ready = bus.out_ready;

   des_perm_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .beat_cnt (beat_cnt)
   );

   des_perm_pipe #(.LANES(1), .CNT_W(4)) dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus1),
      .beat_cnt (beat_cnt1)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // IP as the textbook 8x8 pattern: rows 0-3 start at 58,60,62,64, rows 4-7 at 57..63, step -8.
   function automatic int unsigned ip_src(input int unsigned i);
      int unsigned r = (i - 1) / 8;
      int unsigned c = (i - 1) % 8;
      return (r < 4) ? (58 + 2 * r - 8 * c) : (57 + 2 * (r - 4) - 8 * c);
   endfunction

   // FP is computed as the inverse mapping of IP rather than from its own table.
   function automatic logic [63:0] ref_perm(input logic [63:0] blk, input logic mode,
                                            input logic swap);
      logic [63:0] src;
      logic [63:0] res;
      src = (mode && swap) ? {blk[31:0], blk[63:32]} : blk;
      res = '0;
      for (int unsigned i = 1; i <= 64; i++) begin
         if (!mode) res[64 - i] = src[64 - ip_src(i)];
         else       res[64 - ip_src(i)] = src[64 - i];
      end
      return res;
   endfunction

   function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic mode,
                                             input logic swap);
      logic [W-1:0] r;
      for (int unsigned k = 0; k < LANES; k++)
         r[W-1-64*k -: 64] = ref_perm(d[W-1-64*k -: 64], mode, swap);
      return r;
   endfunction

   function automatic logic [W-1:0] rand_beat();
      logic [W-1:0] r;
      for (int unsigned k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // One cycle: drive at negedge, check the current outputs, then advance the model.
   task automatic step(input logic v, input logic [W-1:0] d, input logic m, input logic s,
                       input logic r, input logic [W-1:0] exp);
      beat_t e;
      logic  take;
      logic  pop;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_mode   = m;
      bus.in_swap   = s;
      bus.out_ready = r;
      #1;
      check("out_valid", bus.out_valid, sb.size() != 0);
      check("in_ready", bus.in_ready, sb.size() < 2);
      check("beat_cnt", beat_cnt, mcnt[CNT_W-1:0]);
      check("l1_out_valid", bus1.out_valid, sb.size() != 0);
      check("l1_in_ready", bus1.in_ready, sb.size() < 2);
      check("l1_beat_cnt", beat_cnt1, mcnt[3:0]);
      if (sb.size() != 0) begin
         check("out_data", bus.out_data, sb[0].data);
         check("out_mode", bus.out_mode, sb[0].mode);
         check("l1_out_data", bus1.out_data, sb[0].data[W-1 -: 64]);
      end
      take = v && (sb.size() < 2);
      pop  = r && (sb.size() != 0);
      @(posedge clk);
      if (pop) void'(sb.pop_front());
      if (take) begin
         e.data = exp;
         e.mode = m;
         sb.push_back(e);
         mcnt++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_beat_cnt", beat_cnt, '0);
      check("rst_out_data", bus.out_data, '0);
      check("rst_out_mode", bus.out_mode, 1'b0);
      check("rst_l1_out_valid", bus1.out_valid, 1'b0);
      sb.delete();
      mcnt = 0;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready_held", bus.in_ready, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         cv;
      logic         cm;
      logic         cs;
      logic         acc;
      logic [W-1:0] cd;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 1'b0;
      bus.in_swap   = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      do_reset();

      // Known-answer vectors, including swap ignored in IP mode
      step(1'b1, {LANES{64'h0123456789ABCDEF}}, 1'b0, 1'b0, 1'b1, {LANES{64'hCC00CCFFF0AAF0AA}});
      step(1'b1, {LANES{64'h0A4CD99543423234}}, 1'b1, 1'b0, 1'b1, {LANES{64'h85E813540F0AB405}});
      step(1'b1, {LANES{64'h434232340A4CD995}}, 1'b1, 1'b1, 1'b1, {LANES{64'h85E813540F0AB405}});
      step(1'b1, {LANES{64'h0123456789ABCDEF}}, 1'b0, 1'b1, 1'b1, {LANES{64'hCC00CCFFF0AAF0AA}});
      idle(2);

      // Round trip IP then FP restores the original block in every lane
      for (int unsigned i = 0; i < 20; i++) begin
         x = rand_beat();
         y = ref_beat(x, 1'b0, 1'b0);
         step(1'b1, x, 1'b0, 1'b0, 1'b1, y);
         step(1'b1, y, 1'b1, 1'b0, 1'b1, x);
      end
      idle(2);

      // Backpressure: third beat is refused, head holds, FIFO order on drain
      for (int unsigned i = 0; i < 3; i++) begin
         x = rand_beat();
         step(1'b1, x, 1'b0, 1'b0, 1'b0, ref_beat(x, 1'b0, 1'b0));
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      idle(3);

      // Streaming from a clean counter; the 4-bit counter wraps at 16
      do_reset();
      for (int unsigned i = 0; i < 100; i++) begin
         x  = rand_beat();
         cm = 1'($urandom_range(0, 1));
         cs = 1'($urandom_range(0, 1));
         step(1'b1, x, cm, cs, 1'b1, ref_beat(x, cm, cs));
         if (i == 16) begin
            check("cnt17", beat_cnt, 17);
            check("cnt17_w4", beat_cnt1, 4'd1);
         end
      end
      check("cnt100", beat_cnt, 100);
      check("cnt100_w4", beat_cnt1, 4'd4);
      idle(2);

      // Random traffic; a refused beat is held until accepted
      cv = 1'b0;
      cd = '0;
      cm = 1'b0;
      cs = 1'b0;
      for (int unsigned i = 0; i < 400; i++) begin
         if (!cv) begin
            cv = 1'($urandom_range(0, 1));
            cd = rand_beat();
            cm = 1'($urandom_range(0, 1));
            cs = 1'($urandom_range(0, 1));
         end
         acc = cv && (sb.size() < 2);
         step(cv, cd, cm, cs, 1'($urandom_range(0, 3) != 0), ref_beat(cd, cm, cs));
         if (acc) cv = 1'b0;
      end

      // Reset with the buffer full; nothing stale may appear afterwards
      idle(3);
      for (int unsigned i = 0; i < 2; i++) begin
         x = rand_beat();
         step(1'b1, x, 1'b1, 1'b0, 1'b0, ref_beat(x, 1'b1, 1'b0));
      end
      check("full_in_ready", bus.in_ready, 1'b0);
      do_reset();
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
